// File: rtl/jc_arb_pkg.sv
// Shared constants and Johnson-code helpers for the slot arbiter.
package jc_arb_pkg;

    localparam int unsigned JC_W_DEF   = 4;
    localparam int unsigned NREQ_DEF   = 4;
    localparam int unsigned NSLOT_DEF  = 2 * JC_W_DEF;
    localparam int unsigned SLOT_W_DEF = $clog2(NSLOT_DEF);
    localparam int unsigned ID_W_DEF   = $clog2(NREQ_DEF);

    // Number of set bits among the low w bits of js.
    function automatic int unsigned js_popcount(input logic [31:0] js, input int unsigned w);
        int unsigned pc;
        pc = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < w && js[5'(i)]) pc++;
        end
        return pc;
    endfunction

    // Slot number of a Johnson code: rising half counts ones, falling half counts down from 2w.
    function automatic int unsigned js_to_slot(input logic [31:0] js, input int unsigned w);
        int unsigned pc;
        pc = js_popcount(js, w);
        return js[5'(w - 1)] ? (2 * w - pc) : pc;
    endfunction

    // A w-bit Johnson code has at most one 0/1 boundary between adjacent bits.
    function automatic logic js_legal(input logic [31:0] js, input int unsigned w);
        int unsigned tr;
        tr = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((i + 1) < w && (js[5'(i)] != js[5'(i + 1)])) tr++;
        end
        return (tr <= 1);
    endfunction

endpackage

// File: rtl/jc_slot_arbiter_seq.sv
// Johnson slot sequencer with illegal-state recovery and sticky error flag.
module jc_seq
    import jc_arb_pkg::*;
#(
    parameter int unsigned JC_W = JC_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic [JC_W-1:0] js,
    output logic            js_err
);

    logic [JC_W-1:0] js_q;
    logic [JC_W-1:0] js_d;
    logic            js_err_q;
    logic            js_err_d;
    logic            legal_c;

    // Next Johnson state; an illegal code snaps back to zero regardless of en.
    always_comb begin
        legal_c  = js_legal(32'(js_q), JC_W);
        js_d     = js_q;
        js_err_d = js_err_q;
        if (!legal_c) begin
            js_d     = '0;
            js_err_d = 1'b1;
        end else if (en) begin
            js_d = {js_q[JC_W-2:0], ~js_q[JC_W-1]};
        end
    end

    // State and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            js_q     <= '0;
            js_err_q <= 1'b0;
        end else begin
            js_q     <= js_d;
            js_err_q <= js_err_d;
        end
    end

    assign js     = js_q;
    assign js_err = js_err_q;

endmodule

// File: rtl/jc_slot_arbiter.sv
// Time-division arbiter: Johnson-sequenced slots, programmable owner table,
// optional round-robin reuse of slots whose owner is idle.
module jc_slot_arbiter
    import jc_arb_pkg::*;
#(
    parameter int unsigned JC_W      = JC_W_DEF,
    parameter int unsigned NREQ      = NREQ_DEF,
    parameter bit          WORK_CONS = 1'b1,
    localparam int unsigned NSLOT    = 2 * JC_W,
    localparam int unsigned SLOT_W   = $clog2(NSLOT),
    localparam int unsigned ID_W     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    output logic              gnt_vld,
    output logic [ID_W-1:0]   gnt_id,
    output logic [SLOT_W-1:0] gnt_slot,
    output logic [JC_W-1:0]   js,
    output logic [SLOT_W-1:0] slot_idx,
    input  logic              cfg_we,
    input  logic [SLOT_W-1:0] cfg_slot,
    input  logic [ID_W-1:0]   cfg_owner,
    output logic              cfg_err,
    output logic              js_err
);

    logic [ID_W-1:0]   owner_q [NSLOT];
    logic [ID_W-1:0]   owner_d [NSLOT];
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   gnt_d;
    logic              gnt_vld_q;
    logic [ID_W-1:0]   gnt_id_q;
    logic [ID_W-1:0]   gnt_id_d;
    logic [SLOT_W-1:0] gnt_slot_q;
    logic              cfg_err_q;
    logic              cfg_err_d;
    logic [ID_W-1:0]   owner_c;
    logic [ID_W-1:0]   idx_c;
    logic              found_c;
    logic              owner_ok_c;
    logic              slot_ok_c;
    logic              cfg_ok_c;

    jc_seq #(
        .JC_W (JC_W)
    ) u_seq (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .js     (js),
        .js_err (js_err)
    );

    assign slot_idx = SLOT_W'(js_to_slot(32'(js), JC_W));

    // Range checks only exist when the field can encode out-of-range values.
    if (NREQ == (1 << ID_W)) begin : g_own_full
        assign owner_ok_c = 1'b1;
    end else begin : g_own_chk
        assign owner_ok_c = (32'(cfg_owner) < NREQ);
    end

    if (NSLOT == (1 << SLOT_W)) begin : g_slot_full
        assign slot_ok_c = 1'b1;
    end else begin : g_slot_chk
        assign slot_ok_c = (32'(cfg_slot) < NSLOT);
    end

    assign cfg_ok_c = owner_ok_c && slot_ok_c;

    // Arbitration: slot owner first, then optional round-robin scan after the owner.
    always_comb begin
        owner_c  = (32'(slot_idx) < NSLOT) ? owner_q[slot_idx] : '0;
        gnt_d    = '0;
        gnt_id_d = '0;
        idx_c    = '0;
        found_c  = 1'b0;
        if (en) begin
            if (req[owner_c]) begin
                found_c  = 1'b1;
                gnt_id_d = owner_c;
            end else if (WORK_CONS) begin
                for (int unsigned k = 1; k < NREQ; k++) begin
                    idx_c = ID_W'((32'(owner_c) + k) % NREQ);
                    if (!found_c && req[idx_c]) begin
                        found_c  = 1'b1;
                        gnt_id_d = idx_c;
                    end
                end
            end
        end
        if (found_c) gnt_d[gnt_id_d] = 1'b1;
    end

    // Slot-table update; a write to the live slot lands after this edge's arbitration.
    always_comb begin
        owner_d   = owner_q;
        cfg_err_d = cfg_we && !cfg_ok_c;
        if (cfg_we && cfg_ok_c) owner_d[cfg_slot] = cfg_owner;
    end

    // Grant, config-error and owner-table registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q      <= '0;
            gnt_vld_q  <= 1'b0;
            gnt_id_q   <= '0;
            gnt_slot_q <= '0;
            cfg_err_q  <= 1'b0;
            for (int unsigned s = 0; s < NSLOT; s++) begin
                owner_q[SLOT_W'(s)] <= ID_W'(s % NREQ);
            end
        end else begin
            gnt_q     <= gnt_d;
            gnt_vld_q <= found_c;
            gnt_id_q  <= gnt_id_d;
            if (en) gnt_slot_q <= slot_idx;
            cfg_err_q <= cfg_err_d;
            owner_q   <= owner_d;
        end
    end

    assign gnt      = gnt_q;
    assign gnt_vld  = gnt_vld_q;
    assign gnt_id   = gnt_id_q;
    assign gnt_slot = gnt_slot_q;
    assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_jc_slot_arbiter.sv
// Directed bench: work-conserving, strict TDM and 3-requester instances share stimulus.
module tb_jc_slot_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, cfg_we;
    logic [3:0] req;
    logic [2:0] req3;
    logic [2:0] cfg_slot;
    logic [1:0] cfg_owner;

    logic [3:0] wc_gnt, td_gnt;
    logic [2:0] n3_gnt;
    logic       wc_vld, td_vld, n3_vld;
    logic [1:0] wc_id, td_id, n3_id;
    logic [2:0] wc_slot, td_slot, n3_slot;
    logic [3:0] wc_js, td_js, n3_js;
    logic [2:0] wc_sidx, td_sidx, n3_sidx;
    logic       wc_cerr, td_cerr, n3_cerr;
    logic       wc_jerr, td_jerr, n3_jerr;

    jc_slot_arbiter #(.JC_W(4), .NREQ(4), .WORK_CONS(1'b1)) dut_wc (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(wc_gnt), .gnt_vld(wc_vld), .gnt_id(wc_id), .gnt_slot(wc_slot),
        .js(wc_js), .slot_idx(wc_sidx),
        .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_owner(cfg_owner),
        .cfg_err(wc_cerr), .js_err(wc_jerr)
    );

    jc_slot_arbiter #(.JC_W(4), .NREQ(4), .WORK_CONS(1'b0)) dut_tdm (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(td_gnt), .gnt_vld(td_vld), .gnt_id(td_id), .gnt_slot(td_slot),
        .js(td_js), .slot_idx(td_sidx),
        .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_owner(cfg_owner),
        .cfg_err(td_cerr), .js_err(td_jerr)
    );

    jc_slot_arbiter #(.JC_W(4), .NREQ(3), .WORK_CONS(1'b0)) dut_n3 (
        .clk(clk), .rst(rst), .en(en), .req(req3),
        .gnt(n3_gnt), .gnt_vld(n3_vld), .gnt_id(n3_id), .gnt_slot(n3_slot),
        .js(n3_js), .slot_idx(n3_sidx),
        .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_owner(cfg_owner),
        .cfg_err(n3_cerr), .js_err(n3_jerr)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] jcode [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                              4'b1111, 4'b1110, 4'b1100, 4'b1000};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_we = 1'b0; req = '0; req3 = '0;
        cfg_slot = '0; cfg_owner = '0;
        repeat (2) step();

        // Reset state
        chk("rst_js",      32'(wc_js),   32'h0);
        chk("rst_sidx",    32'(wc_sidx), 32'h0);
        chk("rst_gnt",     32'(wc_gnt),  32'h0);
        chk("rst_vld",     32'(wc_vld),  32'h0);
        chk("rst_id",      32'(wc_id),   32'h0);
        chk("rst_gslot",   32'(wc_slot), 32'h0);
        chk("rst_cerr",    32'(wc_cerr), 32'h0);
        chk("rst_jerr",    32'(wc_jerr), 32'h0);
        chk("rst_td_all",  32'({td_gnt, td_vld, td_id, td_slot, td_js, td_sidx, td_cerr, td_jerr}), 32'h0);
        chk("rst_n3_all",  32'({n3_gnt, n3_vld, n3_id, n3_slot, n3_js, n3_sidx, n3_cerr, n3_jerr}), 32'h0);
        rst = 1'b0;

        // Mid-run reset clears outputs immediately
        en = 1'b1; req = 4'b1111;
        repeat (3) step();
        chk("mid_pre_id",  32'(wc_id),  32'h2);
        chk("mid_pre_vld", 32'(wc_vld), 32'h1);
        chk("mid_pre_js",  32'(wc_js),  32'h7);
        #2 rst = 1'b1;
        #1;
        chk("mid_gnt",   32'(wc_gnt),  32'h0);
        chk("mid_vld",   32'(wc_vld),  32'h0);
        chk("mid_id",    32'(wc_id),   32'h0);
        chk("mid_gslot", 32'(wc_slot), 32'h0);
        chk("mid_js",    32'(wc_js),   32'h0);
        chk("mid_td_gnt", 32'(td_gnt), 32'h0);
        rst = 1'b0; en = 1'b0; req = '0;

        // Johnson sequence plus strict TDM with all requesting (checks reset table)
        en = 1'b1; req = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            chk("seq_js",   32'(wc_js),   32'(jcode[i % 8]));
            chk("seq_sidx", 32'(wc_sidx), 32'(i % 8));
            step();
            chk("tdm_id",   32'(td_id),   32'(i % 4));
            chk("tdm_gnt",  32'(td_gnt),  32'(1 << (i % 4)));
            chk("tdm_slot", 32'(td_slot), 32'(i % 8));
        end

        // Strict TDM, only requester 0: slots 0 and 4 only; work-conserving always grants 0
        req = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("tdm_r0_gnt", 32'(td_gnt), 32'((i % 4 == 0) ? 4'b0001 : 4'b0000));
            chk("wc_r0_id",   32'(wc_id),  32'h0);
            chk("wc_r0_vld",  32'(wc_vld), 32'h1);
        end

        // Work-conserving, only requester 2
        req = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("wc_r2_id",    32'(wc_id),  32'h2);
            chk("wc_r2_gnt",   32'(wc_gnt), 32'h4);
            chk("tdm_r2_gnt",  32'(td_gnt), 32'((i % 4 == 2) ? 4'b0100 : 4'b0000));
        end

        // Slot 0, owner idle, req 1 and 3: round-robin picks 1
        req = 4'b1010;
        step();
        chk("wc_rr_id",  32'(wc_id),  32'h1);
        chk("wc_rr_gnt", 32'(wc_gnt), 32'h2);
        chk("tdm_rr_vld", 32'(td_vld), 32'h0);

        // Rewrite owner of the live slot 3: old owner this pass, new owner next pass
        req = 4'b1001;
        repeat (2) step();
        chk("cfg_at_slot3", 32'(wc_sidx), 32'h3);
        cfg_we = 1'b1; cfg_slot = 3'd3; cfg_owner = 2'd0;
        step();
        cfg_we = 1'b0;
        chk("cfg_old_id",   32'(td_id),   32'h3);
        chk("cfg_old_vld",  32'(td_vld),  32'h1);
        chk("cfg_old_slot", 32'(td_slot), 32'h3);
        chk("cfg_ok_err",   32'(wc_cerr), 32'h0);
        repeat (7) step();
        step();
        chk("cfg_new_id",   32'(td_id),   32'h0);
        chk("cfg_new_slot", 32'(td_slot), 32'h3);
        chk("cfg_new_wc",   32'(wc_id),   32'h0);

        // Out-of-range owner on the 3-requester instance: error pulse, table untouched
        cfg_we = 1'b1; cfg_slot = 3'd2; cfg_owner = 2'd3;
        step();
        cfg_we = 1'b0;
        chk("cerr_pulse",  32'(n3_cerr), 32'h1);
        chk("cerr_valid4", 32'(wc_cerr), 32'h0);
        step();
        chk("cerr_clear",  32'(n3_cerr), 32'h0);
        repeat (4) step();
        chk("cerr_slot2",  32'(n3_sidx), 32'h2);
        req3 = 3'b100; req = '0;
        step();
        chk("cerr_tbl_gnt", 32'(n3_gnt),  32'h4);
        chk("cerr_tbl_id",  32'(n3_id),   32'h2);
        chk("cerr_tbl_slt", 32'(n3_slot), 32'h2);
        req3 = '0;

        // en=0: no grants, sequence frozen
        en = 1'b0; req = 4'b1111;
        repeat (2) step();
        chk("hold_js",   32'(wc_js),   32'h7);
        chk("hold_sidx", 32'(wc_sidx), 32'h3);
        chk("hold_wc",   32'(wc_vld),  32'h0);
        chk("hold_td",   32'(td_gnt),  32'h0);

        // Illegal Johnson code recovers to zero and sets the sticky flag
        en = 1'b1;
        force dut_wc.u_seq.js_q = 4'b0101;
        #1;
        release dut_wc.u_seq.js_q;
        step();
        chk("rec_js",    32'(wc_js),   32'h0);
        chk("rec_jerr",  32'(wc_jerr), 32'h1);
        chk("rec_other", 32'(td_jerr), 32'h0);
        repeat (2) step();
        chk("rec_js2",   32'(wc_js),   32'h3);
        chk("rec_stick", 32'(wc_jerr), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rec_rst_jerr", 32'(wc_jerr), 32'h0);
        chk("rec_rst_js",   32'(wc_js),   32'h0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
